// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters with phase tracking, sync/blank delay stage, line/frame pulses.
// Define VGA_TIMING_CLKDIV_EN to advance the raster every second Clk (pixel clock = Clk/2).
module vga_timing_gen #(
    parameter int   REZ_MAX_WIDTH = 11,
    parameter int   H_ACTIVE      = 640,
    parameter int   H_FP          = 16,
    parameter int   H_SYNC        = 96,
    parameter int   H_BP          = 48,
    parameter int   V_ACTIVE      = 480,
    parameter int   V_FP          = 10,
    parameter int   V_SYNC        = 2,
    parameter int   V_BP          = 33,
    parameter logic H_SYNC_POL    = 1'b0,
    parameter logic V_SYNC_POL    = 1'b0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    output logic                     Hsync,
    output logic                     Vsync,
    output logic                     Blank,
    output logic                     Line_start,
    output logic                     Frame_start
);

    typedef logic [REZ_MAX_WIDTH-1:0] cnt_t;

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC - 1);
    localparam cnt_t H_BACK_END = cnt_t'(H_SYNC + H_BP - 1);
    localparam cnt_t H_ACT_END  = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam cnt_t H_TOT_END  = cnt_t'(H_TOT - 1);
    localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC - 1);
    localparam cnt_t V_BACK_END = cnt_t'(V_SYNC + V_BP - 1);
    localparam cnt_t V_ACT_END  = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam cnt_t V_TOT_END  = cnt_t'(V_TOT - 1);

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_t;

    phase_t phase_h, phase_h_nxt;
    phase_t phase_v, phase_v_nxt;
    cnt_t   count_h_nxt, count_v_nxt;
    logic   line_nxt, frame_nxt;
    logic   h_wrap, v_wrap;
    logic   pix_en;

    // Phase leaves its state on the advance out of its last counter value; FRONT exits only on wrap.
    function automatic phase_t phase_step(input phase_t ph, input cnt_t cnt,
                                          input cnt_t sync_end, input cnt_t back_end,
                                          input cnt_t act_end);
        phase_step = ph;
        case (ph)
            PH_SYNC:   if (cnt == sync_end) phase_step = PH_BACK;
            PH_BACK:   if (cnt == back_end) phase_step = PH_ACTIVE;
            PH_ACTIVE: if (cnt == act_end)  phase_step = PH_FRONT;
            default:   phase_step = ph;
        endcase
    endfunction

`ifdef VGA_TIMING_CLKDIV_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) pix_en <= 1'b0;
        else      pix_en <= ~pix_en;
    end
`else
    assign pix_en = 1'b1;
`endif

    // Out-of-range counts also wrap, so a corrupted counter recovers within one line/frame.
    assign h_wrap = (Count_h >= H_TOT_END);
    assign v_wrap = (Count_v >= V_TOT_END);

    always_comb begin
        count_h_nxt = Count_h;
        count_v_nxt = Count_v;
        phase_h_nxt = phase_h;
        phase_v_nxt = phase_v;
        line_nxt    = 1'b0;
        frame_nxt   = 1'b0;
        if (pix_en) begin
            if (h_wrap) begin
                count_h_nxt = '0;
                phase_h_nxt = PH_SYNC;
                line_nxt    = 1'b1;
                if (v_wrap) begin
                    count_v_nxt = '0;
                    phase_v_nxt = PH_SYNC;
                    frame_nxt   = 1'b1;
                end else begin
                    count_v_nxt = Count_v + 1'b1;
                    phase_v_nxt = phase_step(phase_v, Count_v, V_SYNC_END, V_BACK_END, V_ACT_END);
                end
            end else begin
                count_h_nxt = Count_h + 1'b1;
                phase_h_nxt = phase_step(phase_h, Count_h, H_SYNC_END, H_BACK_END, H_ACT_END);
            end
        end
    end

    // Stage p0: raster counters, phases and start pulses
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Count_h     <= '0;
            Count_v     <= '0;
            phase_h     <= PH_SYNC;
            phase_v     <= PH_SYNC;
            Line_start  <= 1'b0;
            Frame_start <= 1'b0;
        end else begin
            Count_h     <= count_h_nxt;
            Count_v     <= count_v_nxt;
            phase_h     <= phase_h_nxt;
            phase_v     <= phase_v_nxt;
            Line_start  <= line_nxt;
            Frame_start <= frame_nxt;
        end
    end

    // Stage p1: sync/blank decoded from the p0 phases, one Clk behind the counters
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Hsync <= ~H_SYNC_POL;
            Vsync <= ~V_SYNC_POL;
            Blank <= 1'b1;
        end else begin
            Hsync <= (phase_h == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            Vsync <= (phase_v == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            Blank <= !((phase_h == PH_ACTIVE) && (phase_v == PH_ACTIVE));
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            H_left_margin  <= '0;
            H_right_margin <= '0;
            V_left_margin  <= '0;
            V_right_margin <= '0;
        end else begin
            H_left_margin  <= cnt_t'(H_SYNC + H_BP);
            H_right_margin <= H_ACT_END;
            V_left_margin  <= cnt_t'(V_SYNC + V_BP);
            V_right_margin <= V_ACT_END;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny instance with 1-wide syncs.
// Expected values come from closed-form arithmetic on the number of clocks since reset release.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_CLKDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic        Clk;
    logic        Rst;

    logic [10:0] a_ch, a_cv, a_hl, a_hr, a_vl, a_vr;
    logic        a_hs, a_vs, a_bl, a_ls, a_fs;
    logic [10:0] b_ch, b_cv, b_hl, b_hr, b_vl, b_vr;
    logic        b_hs, b_vs, b_bl, b_ls, b_fs;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen u_dut (
        .Clk(Clk), .Rst(Rst),
        .Count_h(a_ch), .Count_v(a_cv),
        .H_left_margin(a_hl), .H_right_margin(a_hr),
        .V_left_margin(a_vl), .V_right_margin(a_vr),
        .Hsync(a_hs), .Vsync(a_vs), .Blank(a_bl),
        .Line_start(a_ls), .Frame_start(a_fs)
    );

    // H_TOT = 8, V_TOT = 6, active 4x3, positive sync polarity
    vga_timing_gen #(
        .REZ_MAX_WIDTH(11),
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_small (
        .Clk(Clk), .Rst(Rst),
        .Count_h(b_ch), .Count_v(b_cv),
        .H_left_margin(b_hl), .H_right_margin(b_hr),
        .V_left_margin(b_vl), .V_right_margin(b_vr),
        .Hsync(b_hs), .Vsync(b_vs), .Blank(b_bl),
        .Line_start(b_ls), .Frame_start(b_fs)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // k = clocks since reset release (0 while in reset)
    task automatic check_dut(input string nm, input int k,
                             input int hs, input int hb, input int ha, input int hf,
                             input int vs, input int vb, input int va, input int vf,
                             input int pol_h, input int pol_v,
                             input int ch, input int cv, input int hl, input int hr,
                             input int vl, input int vr, input int hsy, input int vsy,
                             input int blk, input int ls, input int fs);
        int ht, vt, p, q, hq, vq;
        int e_ch, e_cv, e_hs, e_vs, e_bl, e_ls, e_fs, e_hl, e_hr, e_vl, e_vr;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        if (k == 0) begin
            e_ch = 0; e_cv = 0; e_hs = 1 - pol_h; e_vs = 1 - pol_v; e_bl = 1;
            e_ls = 0; e_fs = 0; e_hl = 0; e_hr = 0; e_vl = 0; e_vr = 0;
        end else begin
            p  = k / DIV;
            q  = (k - 1) / DIV;
            hq = q % ht;
            vq = (q / ht) % vt;
            e_ch = p % ht;
            e_cv = (p / ht) % vt;
            e_hs = (hq < hs) ? pol_h : 1 - pol_h;
            e_vs = (vq < vs) ? pol_v : 1 - pol_v;
            e_bl = (hq >= hs + hb && hq < hs + hb + ha && vq >= vs + vb && vq < vs + vb + va) ? 0 : 1;
            e_ls = ((k % DIV) == 0 && e_ch == 0) ? 1 : 0;
            e_fs = (e_ls == 1 && e_cv == 0) ? 1 : 0;
            e_hl = hs + hb; e_hr = hs + hb + ha - 1;
            e_vl = vs + vb; e_vr = vs + vb + va - 1;
        end
        check({nm, ".Count_h"}, ch, e_ch);
        check({nm, ".Count_v"}, cv, e_cv);
        check({nm, ".Hsync"}, hsy, e_hs);
        check({nm, ".Vsync"}, vsy, e_vs);
        check({nm, ".Blank"}, blk, e_bl);
        check({nm, ".Line_start"}, ls, e_ls);
        check({nm, ".Frame_start"}, fs, e_fs);
        check({nm, ".H_left_margin"}, hl, e_hl);
        check({nm, ".H_right_margin"}, hr, e_hr);
        check({nm, ".V_left_margin"}, vl, e_vl);
        check({nm, ".V_right_margin"}, vr, e_vr);
    endtask

    task automatic check_all(input int k);
        check_dut("vga", k, 96, 48, 640, 16, 2, 33, 480, 10, 0, 0,
                  int'(a_ch), int'(a_cv), int'(a_hl), int'(a_hr), int'(a_vl), int'(a_vr),
                  int'(a_hs), int'(a_vs), int'(a_bl), int'(a_ls), int'(a_fs));
        check_dut("small", k, 1, 1, 4, 2, 1, 1, 3, 1, 1, 1,
                  int'(b_ch), int'(b_cv), int'(b_hl), int'(b_hr), int'(b_vl), int'(b_vr),
                  int'(b_hs), int'(b_vs), int'(b_bl), int'(b_ls), int'(b_fs));
    endtask

    initial begin
        int ls_cnt, vs_low, blank_low, fs_cnt;
        ls_cnt = 0; vs_low = 0; blank_low = 0; fs_cnt = 0;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_all(0);
        Rst = 1'b1;

        // Run to Count_h=500, Count_v=2 on the default instance
        for (int k = 1; k <= 2100 * DIV; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            check_all(k);
            if (k <= 2000 * DIV) begin
                ls_cnt += int'(a_ls);
                if (a_vs == 1'b0) vs_low++;
            end
            if (k <= 48 * DIV && b_bl == 1'b0) blank_low++;
            if (k <= 96 * DIV) fs_cnt += int'(b_fs);
        end
        check("vga.line_pulses", ls_cnt, 2);
        check("vga.vsync_low_clocks", vs_low, 1600 * DIV);
        check("small.blank_low_clocks", blank_low, 12 * DIV);
        check("small.frame_pulses", fs_cnt, 2);
        check("vga.mid_h", int'(a_ch), 500);
        check("vga.mid_v", int'(a_cv), 2);

        // Mid-frame reset must clear everything without waiting for a clock
        Rst = 1'b0;
        #1;
        check_all(0);
        @(posedge Clk);
        @(negedge Clk);
        check_all(0);
        Rst = 1'b1;
        for (int k = 1; k <= 120 * DIV; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            check_all(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA control path: free-running horizontal/vertical pixel counters, sync pulses, blanking, and static active-region margins. Sits directly upstream of the colour-assignment stage, feeding it `Count_h`, `Count_v` and the four margin values. It drives the monitor's `Hsync`/`Vsync` pins, delayed one clock so they align with the colour stage's registered output.

## Interface
Parameters:
- `REZ_MAX_WIDTH`, 11: width of counters and margin outputs.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `H_SYNC_POL`, 0: asserted level of `Hsync`.
- `V_SYNC_POL`, 0: asserted level of `Vsync`.

Ports:
- `Clk`, in, 1: clock.
- `Rst`, in, 1: reset Rst, asynchronous, active-low.
- `Count_h`, out, `REZ_MAX_WIDTH`: horizontal position, 0..H_TOT-1.
- `Count_v`, out, `REZ_MAX_WIDTH`: vertical position, 0..V_TOT-1.
- `H_left_margin`, out, `REZ_MAX_WIDTH`: first active column, H_SYNC+H_BP.
- `H_right_margin`, out, `REZ_MAX_WIDTH`: last active column, H_SYNC+H_BP+H_ACTIVE-1.
- `V_left_margin`, out, `REZ_MAX_WIDTH`: first active line, V_SYNC+V_BP.
- `V_right_margin`, out, `REZ_MAX_WIDTH`: last active line, V_SYNC+V_BP+V_ACTIVE-1.
- `Hsync`, out, 1: horizontal sync, one-clock delayed.
- `Vsync`, out, 1: vertical sync, one-clock delayed.
- `Blank`, out, 1: high outside the active region, one-clock delayed.
- `Line_start`, out, 1: one-clock pulse when `Count_h` wraps to 0.
- `Frame_start`, out, 1: one-clock pulse when both counters wrap to 0.

## Operation
- Totals: H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOT = V_SYNC+V_BP+V_ACTIVE+V_FP (525).
- Phase order on each axis: SYNC, BACK, ACTIVE, FRONT, then back to SYNC. The counter value 0 is the first SYNC cycle.
- Each axis has a 2-bit phase register (SYNC=0, BACK=1, ACTIVE=2, FRONT=3). Transitions happen on the pixel advance where the counter leaves the last value of the phase:
  - H: SYNC→BACK when Count_h=H_SYNC-1; BACK→ACTIVE at H_SYNC+H_BP-1; ACTIVE→FRONT at H_right_margin; FRONT→SYNC at H_TOT-1.
  - V: same transitions, evaluated only on horizontal wrap.
- `Count_h` increments on every pixel advance and wraps H_TOT-1→0.
- `Count_v` increments only on the horizontal wrap and wraps V_TOT-1→0 when Count_h=H_TOT-1 and Count_v=V_TOT-1.
- Counters never exceed their total; any out-of-range value forces a wrap to 0 on the next advance.
- Margin outputs are constants derived from the parameters, registered once, and driven continuously after reset.
- Output delay stage (updated every `Clk`):
  - Hsync = H_SYNC_POL when the H phase was SYNC, else ~H_SYNC_POL.
  - Vsync is formed the same way from the V phase and V_SYNC_POL.
  - Blank = !(H phase=ACTIVE && V phase=ACTIVE).
- `Line_start` and `Frame_start` are registered pulses, asserted the cycle `Count_h`=0 (and `Count_v`=0 for `Frame_start`) first appears.

## Timing
- Reset values:
  - Count_h=0, Count_v=0, both phases=SYNC.
  - Hsync=~H_SYNC_POL, Vsync=~V_SYNC_POL, Blank=1.
  - Line_start=0, Frame_start=0.
  - Margins=0 during reset, constant values from the first clock after release.
- First clock after reset release: Hsync and Vsync become asserted (they decode counter 0). Counters advance from 0.
- Latency: Hsync/Vsync/Blank trail the counter value they describe by exactly one `Clk`. This matches the colour stage's one-register `Active` delay.
- Reset asserted mid-frame: all state returns to reset values asynchronously, with no partial pulse completion. The frame restarts from (0,0).
- With H_SYNC or V_SYNC equal to 1, the SYNC phase lasts a single advance; the phase logic must not skip it.

## Configuration
- `VGA_TIMING_CLKDIV_EN` defined:
  - An internal pixel-enable toggle divides `Clk` by 2 (e.g. 50 MHz → 25 MHz pixel rate). The toggle resets to 0 and the first advance occurs on the second clock after release.
  - Counters and phases advance only when the enable is 1, so each count is held 2 clocks.
  - `Line_start`/`Frame_start` assert for one `Clk` only.
  - The output delay stage still updates every `Clk`, so one-`Clk` alignment with the colour stage is preserved.
- Undefined: counters advance every `Clk`.

## Test plan
- Reset release, default parameters, divider off → cycle 1: Hsync=0, Vsync=0, Blank=1. Hsync returns to 1 on the cycle after Count_h=96 is output. Margins read 144/783/35/514.
- Run one full line → Count_h sequence 0..799 then 0; Count_v steps 0→1 on the cycle Count_h shows 0; Line_start is high for exactly 1 clock per 800.
- Run one full frame → Vsync is low for 2×800 clocks; Frame_start pulses once per 420000 clocks; Blank is low for exactly 640×480 clocks per frame.
- Blank check at Count_h=144, Count_v=35 → Blank=0 on the following clock; at Count_h=784 → Blank=1 on the following clock.
- Assert Rst at Count_h=500, Count_v=300 → all outputs immediately take reset values; after release, the counting sequence restarts at (0,0).
- `VGA_TIMING_CLKDIV_EN` defined → each Count_h value is held 2 clocks, the line is 1600 clocks, and Hsync still lags the counter by 1 clock.
